// File: rtl/mult8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one 4x4 nibble partial product per clock, four steps per result.
// Optional MULT_ZERO_SKIP_EN: a zero operand bypasses the nibble steps and completes with product=0.
module mult8x8_seq #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] dataa,
  input  logic [2*N-1:0] datab,
  output logic [4*N-1:0] product,
  output logic           done_flag,
  output logic           busy,
  output logic [1:0]     sel
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_d;
  logic [2*N-1:0] a_reg, b_reg, a_d, b_d;
  logic [4*N-1:0] acc, acc_d, product_d, shifted;
  logic [1:0]     sel_d;
  logic           done_d;
  logic           zero_hit, zero_hit_d;
  logic [N-1:0]   a_nib, b_nib;
  logic [2*N-1:0] partial;

  // sel[0] picks the multiplicand nibble, sel[1] the multiplier nibble
  assign a_nib   = sel[0] ? a_reg[2*N-1:N] : a_reg[N-1:0];
  assign b_nib   = sel[1] ? b_reg[2*N-1:N] : b_reg[N-1:0];
  assign partial = {{N{1'b0}}, a_nib} * {{N{1'b0}}, b_nib};
  assign busy    = (state != IDLE);

  // Partial product weight is N bits per high nibble involved: 0, N, N, 2N
  always_comb begin
    shifted = {{2*N{1'b0}}, partial};
    case (sel)
      2'd1, 2'd2: shifted = {{2*N{1'b0}}, partial} << N;
      2'd3:       shifted = {{2*N{1'b0}}, partial} << (2*N);
      default:    shifted = {{2*N{1'b0}}, partial};
    endcase
  end

  always_comb begin
    state_d    = state;
    a_d        = a_reg;
    b_d        = b_reg;
    acc_d      = acc;
    sel_d      = sel;
    product_d  = product;
    done_d     = 1'b0;
    zero_hit_d = zero_hit;
    case (state)
      IDLE: begin
        if (start) begin
          a_d   = dataa;
          b_d   = datab;
          acc_d = '0;
          sel_d = 2'd0;
`ifdef MULT_ZERO_SKIP_EN
          zero_hit_d = (dataa == '0) || (datab == '0);
          state_d    = zero_hit_d ? DONE : CALC;
`else
          zero_hit_d = 1'b0;
          state_d    = CALC;
`endif
        end
      end
      CALC: begin
        acc_d = acc + shifted;
        sel_d = sel + 2'd1;
        // Only the final sum reaches product; intermediate sums stay internal
        if (sel == 2'd3) begin
          product_d = acc_d;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d    = IDLE;
        sel_d      = 2'd0;
        zero_hit_d = 1'b0;
        // A zero-skip pass completes here, one edge after capture
        if (zero_hit) begin
          product_d = '0;
          done_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      sel       <= 2'd0;
      product   <= '0;
      done_flag <= 1'b0;
      zero_hit  <= 1'b0;
    end else begin
      state     <= state_d;
      a_reg     <= a_d;
      b_reg     <= b_d;
      acc       <= acc_d;
      sel       <= sel_d;
      product   <= product_d;
      done_flag <= done_d;
      zero_hit  <= zero_hit_d;
    end
  end

endmodule

// File: tb/tb_mult8x8_seq.sv
// Directed bench for mult8x8_seq: a cycle-level reference model checked every cycle, plus literal expectations.
// Build with and without MULT_ZERO_SKIP_EN; the zero-operand expectations follow the macro.
module tb_mult8x8_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  dataa, datab;
  logic [15:0] product;
  logic        done_flag, busy;
  logic [1:0]  sel;

  int vectors    = 0;
  int miscompares = 0;
  int done_count = 0;

`ifdef MULT_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
  localparam int ZERO_EDGES = 1;
`else
  localparam bit ZERO_SKIP = 1'b0;
  localparam int ZERO_EDGES = 4;
`endif

  mult8x8_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dataa     (dataa),
    .datab     (datab),
    .product   (product),
    .done_flag (done_flag),
    .busy      (busy),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1..4 = nibble step about to be taken, 5 = done cycle,
  // 6 = zero-skip done cycle (result appears on the following edge)
  int          phase = 0;
  logic [7:0]  ma = '0, mb = '0;
  logic [15:0] m_product = '0;
  logic        m_done = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      phase     = 0;
      m_product = '0;
      m_done    = 1'b0;
    end else begin
      m_done = 1'b0;
      if (phase == 0) begin
        if (start) begin
          ma = dataa;
          mb = datab;
          phase = (ZERO_SKIP && (dataa == 8'd0 || datab == 8'd0)) ? 6 : 1;
        end
      end else if (phase == 4) begin
        m_product = {8'd0, ma} * {8'd0, mb};
        m_done    = 1'b1;
        phase     = 5;
      end else if (phase == 5) begin
        phase = 0;
      end else if (phase == 6) begin
        m_product = 16'd0;
        m_done    = 1'b1;
        phase     = 0;
      end else begin
        phase = phase + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, shortly after the edge, compare all outputs with the model
  always @(posedge clk) begin
    #2;
    checkOutput("cyc_product", product, m_product);
    checkOutput("cyc_done", done_flag, m_done);
    checkOutput("cyc_busy", busy, (phase != 0));
    checkOutput("cyc_sel", sel, (phase >= 1 && phase <= 4) ? 2'(phase - 1) : 2'd0);
    if (done_flag === 1'b1) done_count++;
  end

  // One-edge start request; returns at the falling edge after the sampling edge (E0)
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    dataa = a;
    datab = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int budget, output int edges);
    edges = 0;
    while (done_flag !== 1'b1 && edges < budget) begin
      @(posedge clk);
      #2;
      edges++;
    end
    if (done_flag !== 1'b1) checkOutput("done_timeout", {31'd0, done_flag}, 32'd1);
  endtask

  int edges;
  int snap;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    datab = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_product", product, 16'h0000);
    checkOutput("reset_done", done_flag, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_sel", sel, 2'd0);

    // Max operands with explicit step-by-step timing
    applyStimulus(8'hFF, 8'hFF);
    checkOutput("max_sel_e0", sel, 2'd0);
    checkOutput("max_busy_e0", busy, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #2;
      checkOutput("max_sel_step", sel, i[1:0]);
      checkOutput("max_done_early", done_flag, 1'b0);
    end
    @(posedge clk);
    #2;
    checkOutput("max_done_e4", done_flag, 1'b1);
    checkOutput("max_product", product, 16'hFE01);
    checkOutput("model_max", m_product, 16'hFE01);
    @(posedge clk);
    #2;
    checkOutput("max_done_e5", done_flag, 1'b0);
    checkOutput("max_busy_e5", busy, 1'b0);

    // Mixed nibbles then back-to-back at the first idle edge
    applyStimulus(8'hA5, 8'h3C);
    waitDone(10, edges);
    checkOutput("mixed_latency", edges, 32'd4);
    checkOutput("mixed_product", product, 16'h26AC);
    checkOutput("model_mixed", m_product, 16'h26AC);
    @(posedge clk);
    #2;
    applyStimulus(8'h12, 8'h34);
    checkOutput("b2b_hold", product, 16'h26AC);
    waitDone(10, edges);
    checkOutput("b2b_latency", edges, 32'd4);
    checkOutput("b2b_product", product, 16'h03A8);
    @(posedge clk);
    #2;

    // Busy protection: extra starts at E2 and during DONE must be ignored
    snap = done_count;
    applyStimulus(8'h07, 8'h09);
    @(negedge clk);
    start = 1'b1;
    dataa = 8'hFF;
    datab = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    waitDone(10, edges);
    checkOutput("busy_latency", edges, 32'd2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("busy_product", product, 16'h003F);
    checkOutput("busy_pulses", done_count - snap, 32'd1);
    checkOutput("model_busy", m_product, 16'h003F);

    // Reset mid-operation
    applyStimulus(8'hC8, 8'h64);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_product", product, 16'h0000);
    checkOutput("rst_done", done_flag, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_sel", sel, 2'd0);
    snap = done_count;
    repeat (8) @(negedge clk);
    checkOutput("rst_no_pulse", done_count - snap, 32'd0);
    applyStimulus(8'h02, 8'h03);
    waitDone(10, edges);
    checkOutput("post_rst_product", product, 16'h0006);
    @(posedge clk);
    #2;

    // Zero operand
    applyStimulus(8'h00, 8'h5A);
    checkOutput("zero_busy_e0", busy, 1'b1);
    waitDone(10, edges);
    checkOutput("zero_latency", edges, ZERO_EDGES);
    checkOutput("zero_product", product, 16'h0000);
    repeat (4) @(negedge clk);
    checkOutput("zero_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
